// File: rtl/flopenr_pipe_pkg.sv
// Shared definitions for the flopenr pipeline register: default sizes, stage operation decode and
// count-width helper. Optional parity storage is enabled by defining FLOPENR_PIPE_PARITY_EN.
package flopenr_pipe_pkg;

  localparam int unsigned FLOPENR_PIPE_DEF_WIDTH = 32;
  localparam int unsigned FLOPENR_PIPE_DEF_DEPTH = 3;

  typedef enum logic [1:0] {
    OpHold,
    OpShift,
    OpFlush
  } stage_op_e;

  // Width needed to hold an occupancy value in 0..d.
  function automatic int unsigned cnt_w(input int unsigned d);
    return $clog2(d + 1);
  endfunction

  // Flush wins over advance; neither means hold.
  function automatic stage_op_e decode_op(input logic flush, input logic en);
    if (flush) return OpFlush;
    if (en) return OpShift;
    return OpHold;
  endfunction

endpackage

// File: rtl/flopenr_stage.sv
// One enabled, flushable pipeline stage holding data, a valid bit and, with
// FLOPENR_PIPE_PARITY_EN defined, a stored even-parity bit.
module flopenr_stage
  import flopenr_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = FLOPENR_PIPE_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             dvalid,
`ifdef FLOPENR_PIPE_PARITY_EN
  input  logic             dpar,
  output logic             qpar,
`endif
  output logic [WIDTH-1:0] q,
  output logic             qvalid
);

  stage_op_e        op;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  assign op = decode_op(flush, E);

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    unique case (op)
      OpFlush: begin
        data_d  = '0;
        valid_d = 1'b0;
      end
      OpShift: begin
        data_d  = d;
        valid_d = dvalid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q      = data_q;
  assign qvalid = valid_q;

`ifdef FLOPENR_PIPE_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    unique case (op)
      OpFlush: par_d = 1'b0;
      OpShift: par_d = dpar;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign qpar = par_q;
`endif

endmodule

// File: rtl/flopenr_pipe.sv
// DEPTH-stage, WIDTH-bit enabled pipeline register with valid bits, flush and occupancy count.
// Define FLOPENR_PIPE_PARITY_EN to store per-stage parity and report perr on the last stage.
module flopenr_pipe
  import flopenr_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = FLOPENR_PIPE_DEF_WIDTH,
  parameter int unsigned DEPTH = FLOPENR_PIPE_DEF_DEPTH,
  localparam int unsigned CW   = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E,
  input  logic             flush,
  input  logic [WIDTH-1:0] D,
  input  logic             Dvalid,
  output logic [WIDTH-1:0] Q,
  output logic             Qvalid,
  output logic [CW-1:0]    count,
  output logic             perr
);

  logic [WIDTH-1:0] in_data  [DEPTH];
  logic             in_valid [DEPTH];
  logic [WIDTH-1:0] st_data  [DEPTH];
  logic             st_valid [DEPTH];

  assign in_data[0]  = D;
  assign in_valid[0] = Dvalid;

  for (genvar i = 1; i < DEPTH; i++) begin : g_link
    assign in_data[i]  = st_data[i-1];
    assign in_valid[i] = st_valid[i-1];
  end

`ifdef FLOPENR_PIPE_PARITY_EN
  logic in_par [DEPTH];
  logic st_par [DEPTH];

  // Even parity: the stored bit makes ^{data, par} zero.
  assign in_par[0] = ^D;
  for (genvar i = 1; i < DEPTH; i++) begin : g_par_link
    assign in_par[i] = st_par[i-1];
  end
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    flopenr_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .E     (E),
      .flush (flush),
      .d     (in_data[i]),
      .dvalid(in_valid[i]),
`ifdef FLOPENR_PIPE_PARITY_EN
      .dpar  (in_par[i]),
      .qpar  (st_par[i]),
`endif
      .q     (st_data[i]),
      .qvalid(st_valid[i])
    );
  end

  assign Q      = st_data[DEPTH-1];
  assign Qvalid = st_valid[DEPTH-1];

  // Occupancy tracked incrementally: one entry in, the last stage's entry out.
  stage_op_e     op;
  logic [CW-1:0] count_q, count_d;

  assign op = decode_op(flush, E);

  always_comb begin
    count_d = count_q;
    unique case (op)
      OpFlush: count_d = '0;
      OpShift: count_d = count_q + CW'(Dvalid) - CW'(st_valid[DEPTH-1]);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifdef FLOPENR_PIPE_PARITY_EN
  assign perr = Qvalid & ((^Q) != st_par[DEPTH-1]);
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_flopenr_pipe.sv
// Directed bench for flopenr_pipe (WIDTH=32, DEPTH=3) with a queue-based pipeline scoreboard.
module tb_flopenr_pipe;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             E;
  logic             flush;
  logic [WIDTH-1:0] D;
  logic             Dvalid;
  logic [WIDTH-1:0] Q;
  logic             Qvalid;
  logic [1:0]       count;
  logic             perr;

  int checks = 0;
  int errors = 0;

  // Expected stage contents {data, valid}; index 0 is stage 0, back is the output stage.
  logic [WIDTH:0] pipe [$];

  flopenr_pipe #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .E     (E),
    .flush (flush),
    .D     (D),
    .Dvalid(Dvalid),
    .Q     (Q),
    .Qvalid(Qvalid),
    .count (count),
    .perr  (perr)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    pipe = {};
    for (int i = 0; i < DEPTH; i++) pipe.push_back('0);
  endtask

  function automatic int unsigned model_count();
    int unsigned n = 0;
    foreach (pipe[i]) n += pipe[i][0];
    return n;
  endfunction

  task automatic check_model(input string tag);
    logic [WIDTH:0] last;
    last = pipe[DEPTH-1];
    check({tag, ".q"}, Q, last[WIDTH:1]);
    check({tag, ".qvalid"}, 32'(Qvalid), 32'(last[0]));
    check({tag, ".count"}, 32'(count), model_count());
    check({tag, ".perr"}, 32'(perr), 32'd0);
  endtask

  // Drive inputs, take one rising edge, update the model, compare on the falling edge.
  task automatic step(input string tag, input logic e, input logic f, input logic [WIDTH-1:0] d,
                      input logic dv);
    E      = e;
    flush  = f;
    D      = d;
    Dvalid = dv;
    @(posedge clk);
    if (f) begin
      model_clear();
    end else if (e) begin
      pipe.push_front({d, dv});
      void'(pipe.pop_back());
    end
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    model_clear();
    reset  = 1'b0;
    E      = 1'b1;
    flush  = 1'b0;
    D      = 32'd94;
    Dvalid = 1'b1;

    // Held in reset across two edges despite valid input.
    repeat (2) begin
      @(negedge clk);
      check("rst.q", Q, 32'd0);
      check("rst.qvalid", 32'(Qvalid), 32'd0);
      check("rst.count", 32'(count), 32'd0);
      check("rst.perr", 32'(perr), 32'd0);
    end
    reset = 1'b1;

    // Fill and observe the three-edge latency.
    step("fill0", 1'b1, 1'b0, 32'd94, 1'b1);
    step("fill1", 1'b1, 1'b0, 32'd95, 1'b1);
    step("fill2", 1'b1, 1'b0, 32'd96, 1'b1);
    check("lat.q", Q, 32'd94);
    check("lat.count", 32'(count), 32'd3);
    step("drain", 1'b1, 1'b0, 32'd97, 1'b0);
    check("drain.q", Q, 32'd95);
    check("drain.count", 32'(count), 32'd2);

    // Hold with changing input, then resume from held values.
    for (int i = 0; i < 4; i++) step("hold", 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    check("hold.q", Q, 32'd95);
    check("hold.count", 32'(count), 32'd2);
    step("resume", 1'b1, 1'b0, 32'h11, 1'b1);
    check("resume.q", Q, 32'd96);

    // Flush beats enable; 7 must never reach the output.
    step("flush", 1'b1, 1'b1, 32'd7, 1'b1);
    check("flush.count", 32'(count), 32'd0);
    step("post0", 1'b1, 1'b0, 32'd1, 1'b1);
    step("post1", 1'b1, 1'b0, 32'd2, 1'b1);
    step("post2", 1'b1, 1'b0, 32'd3, 1'b0);
    check("post.q", Q, 32'd1);
    check("post.count", 32'(count), 32'd2);

    // Asynchronous reset pulse between edges.
    #3 reset = 1'b0;
    #2;
    check("areset.q", Q, 32'd0);
    check("areset.qvalid", 32'(Qvalid), 32'd0);
    check("areset.count", 32'(count), 32'd0);
    #2 reset = 1'b1;
    model_clear();
    step("reload0", 1'b1, 1'b0, 32'd5, 1'b1);
    step("reload1", 1'b1, 1'b0, 32'd6, 1'b1);
    step("reload2", 1'b1, 1'b0, 32'd8, 1'b0);
    check("reload.q", Q, 32'd5);
    check("reload.count", 32'(count), 32'd2);

`ifdef FLOPENR_PIPE_PARITY_EN
    // Corrupt the output stage directly; stored parity no longer matches.
    dut.g_stage[2].u_stage.data_q[0] = ~dut.g_stage[2].u_stage.data_q[0];
    #1;
    check("par.perr", 32'(perr), 32'd1);
    step("par.flush", 1'b1, 1'b1, 32'd9, 1'b1);
    check("par.clear", 32'(perr), 32'd0);
`else
    step("noparity", 1'b1, 1'b0, 32'hA5, 1'b1);
    check("noparity.perr", 32'(perr), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
